brc_sched: RTL
==============

// Module: brc_sched
// PURPOSE
//  Shares a single 32-bit branch comparator (one brc instance) between two requesters.
//  Req0 is branch resolution (funct3-coded). Req1 is set-less-than (SLT/SLTU).
//  Arbitrates, latches operands, sequences the compare and returns a registered result.
//  Uses a valid/ready handshake on every side. Sits between decode/issue and the PC/writeback logic.
// PARAMETERS
//  PRIO_FIXED  0  0: round-robin between req0/req1; 1: req0 always wins when both valid
//  TAG_W       4  width of the requester tag echoed on the response
// PORTS
//  i_clk            in   1      clock; all state updates on rising edge
//  i_rst_n          in   1      reset, asynchronous, active-low
//  i_req0_valid     in   1      branch request valid
//  o_req0_ready     out  1      branch request accepted this cycle (valid&ready)
//  i_req0_rs1       in   32     branch operand A
//  i_req0_rs2       in   32     branch operand B
//  i_req0_funct3    in   3      RV32I branch funct3
//  i_req0_tag       in   TAG_W  requester tag
//  i_req1_valid     in   1      SLT request valid
//  o_req1_ready     out  1      SLT request accepted this cycle
//  i_req1_rs1       in   32     SLT operand A
//  i_req1_rs2       in   32     SLT operand B
//  i_req1_unsigned  in   1      1: SLTU, 0: SLT
//  i_req1_tag       in   TAG_W  requester tag
//  o_rsp_valid      out  1      response valid
//  i_rsp_ready      in   1      consumer accepts response
//  o_rsp_src        out  1      0: req0 response, 1: req1 response
//  o_rsp_tag        out  TAG_W  tag of the serviced request
//  o_rsp_less       out  1      rs1 < rs2 (signedness per request)
//  o_rsp_equal      out  1      rs1 == rs2
//  o_rsp_taken      out  1      branch taken (req0 only; 0 for req1)
//  o_rsp_illegal    out  1      req0 funct3 is 010 or 011
//  o_busy           out  1      FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, all o_rsp_* = 0, o_busy=0, rr pointer last_grant=1 (req0 wins first).
//  - FSM: IDLE -(handshake)-> CMP -> RESP -(o_rsp_valid & i_rsp_ready)-> IDLE.
//  - IDLE, grant:
//      - Only valid requesters are eligible.
//      - If both are valid: PRIO_FIXED=1 grants req0; PRIO_FIXED=0 grants the requester != last_grant.
//      - o_reqN_ready = (state==IDLE) & grantN. Both ready are 0 in CMP/RESP.
//      - The ready path is combinational from the valids; at most one ready is high.
//  - Handshake (edge N): latch rs1, rs2, tag, src, mode; last_grant<=src; state<=CMP.
//  - CMP (edge N+1): comparator sees only latched operands; less/equal/taken/illegal are registered.
//  - RESP: o_rsp_valid=1 from after edge N+1. Min latency accept->valid = 2 cycles; min period 3 cycles.
//  - Signedness: the comparator port i_br_un=1 selects SIGNED, 0 selects unsigned.
//      - req0: signed for funct3 000/001/100/101/010/011; unsigned for 110/111.
//      - req1: i_br_un = ~i_req1_unsigned.
//  - taken:
//      - BEQ(000) = equal; BNE(001) = ~equal; BLT/BLTU(100/110) = less; BGE/BGEU(101/111) = ~less.
//      - 010/011: taken=0, illegal=1; less/equal are still reported.
//  - req1: taken=0, illegal=0; SLT result = {31'b0, o_rsp_less} (formed by consumer).
//  - Backpressure: while o_rsp_valid & ~i_rsp_ready, all o_rsp_* hold stable and no new grant is issued.
//  - Requester obligation: hold operands stable while valid & ~ready. A valid dropped before ready is ignored.
//  - o_rsp_valid drops on the edge after the response handshake. The next grant is evaluated in IDLE on the following cycle.
//  - Reset mid-operation (any state): outputs clear immediately (async).
//      - The in-flight request is dropped; no response is produced after release.
// TESTING
//  1. req0 BLT rs1=0xFFFFFFFF rs2=0x1, rsp_ready=1 -> valid 2 cyc after accept, less=1, taken=1, src=0.
//  2. req0 BLTU same operands -> less=0, taken=0; BGEU -> taken=1.
//  3. req0 BEQ rs1=rs2=0x80000000 -> equal=1, taken=1; BNE -> taken=0.
//  4. Both valid continuously, PRIO_FIXED=0, tags 0xA/0x5:
//     - response order src 0,1,0,1 with matching tags.
//     - With PRIO_FIXED=1 -> src 0 every time until req0 deasserts.
//  5. req1 SLT rs1=0xFFFFFFFE rs2=0x2 -> less=1; SLTU -> less=0; taken=0, illegal=0 in both.
//  6. funct3=010 -> illegal=1, taken=0.
//     - Then hold rsp_ready=0 5 cyc: outputs stable, both ready=0, busy=1.
//     - Then assert i_rst_n=0 during CMP: rsp_valid=0 at once, no response after release.

Source files
------------

// File: rtl/brc_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : brc_sched_if
//  Description : Request/response bundle for the shared branch-compare
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface brc_sched_if #(
    parameter int TAG_W = 4
);
    logic             i_req0_valid;
    logic             o_req0_ready;
    logic [31:0]      i_req0_rs1;
    logic [31:0]      i_req0_rs2;
    logic [2:0]       i_req0_funct3;
    logic [TAG_W-1:0] i_req0_tag;

    logic             i_req1_valid;
    logic             o_req1_ready;
    logic [31:0]      i_req1_rs1;
    logic [31:0]      i_req1_rs2;
    logic             i_req1_unsigned;
    logic [TAG_W-1:0] i_req1_tag;

    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic             o_rsp_src;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             o_rsp_less;
    logic             o_rsp_equal;
    logic             o_rsp_taken;
    logic             o_rsp_illegal;
    logic             o_busy;

    // Requesters and response consumer
    modport master (
        output i_req0_valid, i_req0_rs1, i_req0_rs2, i_req0_funct3, i_req0_tag,
        output i_req1_valid, i_req1_rs1, i_req1_rs2, i_req1_unsigned, i_req1_tag,
        output i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp_valid, o_rsp_src, o_rsp_tag, o_rsp_less, o_rsp_equal,
        input  o_rsp_taken, o_rsp_illegal, o_busy
    );

    // Scheduler
    modport slave (
        input  i_req0_valid, i_req0_rs1, i_req0_rs2, i_req0_funct3, i_req0_tag,
        input  i_req1_valid, i_req1_rs1, i_req1_rs2, i_req1_unsigned, i_req1_tag,
        input  i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_rsp_valid, o_rsp_src, o_rsp_tag, o_rsp_less, o_rsp_equal,
        output o_rsp_taken, o_rsp_illegal, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/brc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : brc_sched (with comparator brc)
//  Description : Arbitrates branch-resolve and SLT requests onto one 32-bit
//                comparator and returns a registered compare result.
//  Revision    : 1.0 - initial release
// ============================================================================

// Note the inverted-looking polarity: i_br_un = 1 selects a SIGNED compare.
module brc (
    input  wire logic [31:0] i_rs1,
    input  wire logic [31:0] i_rs2,
    input  wire logic        i_br_un,
    output logic             o_br_lt,
    output logic             o_br_eq
);
    assign o_br_eq = (i_rs1 == i_rs2);
    assign o_br_lt = i_br_un ? ($signed(i_rs1) < $signed(i_rs2)) : (i_rs1 < i_rs2);
endmodule

module brc_sched #(
    parameter int PRIO_FIXED = 0,
    parameter int TAG_W      = 4
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst_n,
    brc_sched_if.slave  bus
);
    localparam logic c_fixed = (PRIO_FIXED != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_last_grant;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [TAG_W-1:0] r_tag;
    logic             r_src;
    logic             r_signed;
    logic [2:0]       r_funct3;

    logic             r_rsp_valid;
    logic             r_rsp_src;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_less;
    logic             r_rsp_equal;
    logic             r_rsp_taken;
    logic             r_rsp_illegal;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_lt;
    logic             w_eq;
    logic             w_taken;
    logic             w_illegal;

    // req0 wins when alone, under fixed priority, or when req1 was served last.
    assign w_grant0 = bus.i_req0_valid & (~bus.i_req1_valid | c_fixed | r_last_grant);
    assign w_grant1 = bus.i_req1_valid & ~w_grant0;

    assign bus.o_req0_ready = (r_state == S_IDLE) & w_grant0;
    assign bus.o_req1_ready = (r_state == S_IDLE) & w_grant1;

    brc u_brc (
        .i_rs1   (r_rs1),
        .i_rs2   (r_rs2),
        .i_br_un (r_signed),
        .o_br_lt (w_lt),
        .o_br_eq (w_eq)
    );

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        if (!r_src) begin
            case (r_funct3)
                3'b000:         w_taken   = w_eq;
                3'b001:         w_taken   = ~w_eq;
                3'b100, 3'b110: w_taken   = w_lt;
                3'b101, 3'b111: w_taken   = ~w_lt;
                3'b010, 3'b011: w_illegal = 1'b1;
                default:        w_taken   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_last_grant  <= 1'b1;
            r_rs1         <= 32'd0;
            r_rs2         <= 32'd0;
            r_tag         <= '0;
            r_src         <= 1'b0;
            r_signed      <= 1'b0;
            r_funct3      <= 3'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_src     <= 1'b0;
            r_rsp_tag     <= '0;
            r_rsp_less    <= 1'b0;
            r_rsp_equal   <= 1'b0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_src        <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_rs1        <= w_grant1 ? bus.i_req1_rs1 : bus.i_req0_rs1;
                        r_rs2        <= w_grant1 ? bus.i_req1_rs2 : bus.i_req0_rs2;
                        r_tag        <= w_grant1 ? bus.i_req1_tag : bus.i_req0_tag;
                        r_funct3     <= w_grant1 ? 3'b000 : bus.i_req0_funct3;
                        // Only BLTU/BGEU (11x) compare unsigned on the branch side.
                        r_signed     <= w_grant1 ? ~bus.i_req1_unsigned
                                                 : ~(bus.i_req0_funct3[2] & bus.i_req0_funct3[1]);
                        r_busy       <= 1'b1;
                        r_state      <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_rsp_valid   <= 1'b1;
                    r_rsp_src     <= r_src;
                    r_rsp_tag     <= r_tag;
                    r_rsp_less    <= w_lt;
                    r_rsp_equal   <= w_eq;
                    r_rsp_taken   <= w_taken;
                    r_rsp_illegal <= w_illegal;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_rsp_valid   = r_rsp_valid;
    assign bus.o_rsp_src     = r_rsp_src;
    assign bus.o_rsp_tag     = r_rsp_tag;
    assign bus.o_rsp_less    = r_rsp_less;
    assign bus.o_rsp_equal   = r_rsp_equal;
    assign bus.o_rsp_taken   = r_rsp_taken;
    assign bus.o_rsp_illegal = r_rsp_illegal;
    assign bus.o_busy        = r_busy;
endmodule
`default_nettype wire
